xmm_q15_fpu: RTL

Fixed-point arithmetic unit that produces the 64-bit FPU result consumed by the XMM register write-select stage on source code 3'b110. Operands are Q15 words: signed 64-bit two's complement with the low 15 bits fractional, so 1.0 = 64'h8000. Single-cycle ops are add, sub, neg, abs and mul. Division is iterative and multi-cycle, controlled by a start/busy/res_valid handshake.

---
 rtl/xmm_fpu_pkg.sv | 24 ++
 rtl/xmm_q15_divider.sv | 57 +++++
 rtl/xmm_q15_fpu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/xmm_fpu_pkg.sv
// Shared constants for the Q15 fixed-point FPU: widths, op codes,
// saturation bounds and FSM state encodings.
package xmm_fpu_pkg;

  localparam int Q_WIDTH     = 64;
  localparam int Q_FRAC      = 15;
  localparam int Q_DIV_ITERS = Q_WIDTH + Q_FRAC;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NEG = 3'b100;
  localparam logic [2:0] OP_ABS = 3'b101;

  localparam logic [63:0] Q15_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q15_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Q15_ONE = 64'h0000_0000_0000_8000;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIV_ITER = 2'd1;
  localparam logic [1:0] ST_DIV_FIX  = 2'd2;

endpackage

// File: rtl/xmm_q15_divider.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
// The dividend is shifted out of the quotient register as quotient bits shift in.
module xmm_q15_divider #(
  parameter int WIDTH = 64,
  parameter int DW    = 79,
  parameter int ITERS = 79
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [DW-1:0]    dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [DW-1:0]    quotient,
  output logic             done
);

  localparam int CW = $clog2(ITERS);

  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // rem < divisor always holds, so the shifted remainder fits WIDTH+1 bits
  // and a borrow out of diff means the trial subtraction failed.
  assign rem_sh = {rem, quotient[DW-1]};
  assign diff   = rem_sh - {1'b0, dvsr};
  assign done   = (count == CW'(ITERS - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient <= '0;
      rem      <= '0;
      dvsr     <= '0;
      count    <= '0;
    end else if (load) begin
      quotient <= dividend;
      rem      <= '0;
      dvsr     <= divisor;
      count    <= '0;
    end else if (step) begin
      count <= count + 1'b1;
      if (!diff[WIDTH]) begin
        rem      <= diff[WIDTH-1:0];
        quotient <= {quotient[DW-2:0], 1'b1};
      end else begin
        rem      <= rem_sh[WIDTH-1:0];
        quotient <= {quotient[DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/xmm_q15_fpu.sv
// Q15 fixed-point FPU: single-cycle add/sub/mul/neg/abs with saturation,
// plus a multi-cycle signed division built on an unsigned restoring core.
module xmm_q15_fpu
  import xmm_fpu_pkg::*;
#(
  parameter int WIDTH     = Q_WIDTH,
  parameter int FRAC_BITS = Q_FRAC,
  parameter int DIV_ITERS = WIDTH + FRAC_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res,
  output logic             ovf,
  output logic             div_zero
);

  localparam int DW = WIDTH + FRAC_BITS;
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic             div_neg, a_neg_r, a_zero_r, b_zero_r;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [DW-1:0]    quot;
  logic             div_done, div_load, div_step;

  logic [WIDTH:0]           sum, dif;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH-1:0]         nres, fix_res;
  logic                     novf, fix_ovf, prod_fits, neg_big, pos_big;

  assign busy     = (state != ST_IDLE);
  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign div_load = (state == ST_IDLE) && start && (op == OP_DIV);
  assign div_step = (state == ST_DIV_ITER);

  xmm_q15_divider #(.WIDTH(WIDTH), .DW(DW), .ITERS(DIV_ITERS)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (div_step),
    .dividend ({a_mag, {FRAC_BITS{1'b0}}}),
    .divisor  (b_mag),
    .quotient (quot),
    .done     (div_done)
  );

  assign sum       = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign dif       = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign prod      = (2*WIDTH)'($signed(a)) * (2*WIDTH)'($signed(b));
  assign prod_sh   = prod >>> FRAC_BITS;
  assign prod_fits = (&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]);

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    nres = '0;
    novf = 1'b0;
    case (op)
      OP_ADD: begin
        novf = sum[WIDTH] ^ sum[WIDTH-1];
        nres = novf ? (sum[WIDTH] ? MIN_V : MAX_V) : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        novf = dif[WIDTH] ^ dif[WIDTH-1];
        nres = novf ? (dif[WIDTH] ? MIN_V : MAX_V) : dif[WIDTH-1:0];
      end
      OP_MUL: begin
        novf = !prod_fits;
        nres = novf ? (prod_sh[2*WIDTH-1] ? MIN_V : MAX_V) : prod_sh[WIDTH-1:0];
      end
      OP_NEG, OP_ABS: begin
        novf = (a == MIN_V);
        if (novf)                             nres = MAX_V;
        else if (op == OP_NEG || a[WIDTH-1])  nres = -a;
        else                                  nres = a;
      end
      default: ;
    endcase
  end

  // Negative quotients may reach exactly 2^(WIDTH-1) (= MIN); positives may not.
  assign pos_big = |quot[DW-1:WIDTH-1];
  assign neg_big = (|quot[DW-1:WIDTH]) || (quot[WIDTH-1] && (|quot[WIDTH-2:0]));

  always_comb begin
    fix_res = '0;
    fix_ovf = 1'b0;
    if (b_zero_r) begin
      fix_res = a_zero_r ? '0 : (a_neg_r ? MIN_V : MAX_V);
    end else if (div_neg) begin
      fix_ovf = neg_big;
      fix_res = neg_big ? MIN_V : -quot[WIDTH-1:0];
    end else begin
      fix_ovf = pos_big;
      fix_res = pos_big ? MAX_V : quot[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      res_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      div_neg   <= 1'b0;
      a_neg_r   <= 1'b0;
      a_zero_r  <= 1'b0;
      b_zero_r  <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && op == OP_DIV) begin
            state    <= ST_DIV_ITER;
            div_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg_r  <= a[WIDTH-1];
            a_zero_r <= (a == '0);
            b_zero_r <= (b == '0);
          end else if (start) begin
            res       <= nres;
            ovf       <= novf;
            div_zero  <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        ST_DIV_ITER: if (div_done) state <= ST_DIV_FIX;
        ST_DIV_FIX: begin
          res       <= fix_res;
          ovf       <= fix_ovf;
          div_zero  <= b_zero_r;
          res_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
